// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the serial-adder sequencing stage.
package serial_add_pkg;

    localparam int unsigned SERIAL_ADD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; LSB first, zeros shifted in at the MSB.
module piso_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] load_data,
    output logic         ser_out
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift_en) begin
            data_d = {1'b0, data_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_out = data_q[0];

endmodule

// File: rtl/serial_add_sequencer.sv
// Feeds two parallel operands LSB-first into an external 1-bit serial adder
// and collects its sum bits back into a parallel W-bit sum plus carry-out.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int unsigned W = SERIAL_ADD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         ser_a,
    output logic         ser_b,
    output logic         adder_clr,
    input  logic         ser_sum,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_carry
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             in_ready_q, in_ready_d;
    logic             adder_clr_q, adder_clr_d;
    logic             out_valid_q, out_valid_d;
    logic             load;
    logic             shift_en;

    // Operand registers shift in zeros, so after W+1 shifts they are empty and
    // the serial outputs are 0 on the carry-flush cycle and back in IDLE.
    piso_shift_reg #(.W(W)) u_piso_a (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift_en  (shift_en),
        .load_data (in_a),
        .ser_out   (ser_a)
    );

    piso_shift_reg #(.W(W)) u_piso_b (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift_en  (shift_en),
        .load_data (in_b),
        .ser_out   (ser_b)
    );

    // Next-state, counter and result capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        load     = 1'b0;
        shift_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W)) begin
                    carry_d = ser_sum;
                    state_d = DONE;
                end else begin
                    // Bit cnt lands at position cnt once all W bits are in.
                    sum_d = {ser_sum, sum_q[W-1:1]};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        adder_clr_d = (state_d != SHIFT);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            adder_clr_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            adder_clr_q <= adder_clr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign adder_clr = adder_clr_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_carry = carry_q;

endmodule
